instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control unit that drives the 8-register/G/A/EXTERN bus datapath.
- Each instruction runs as: fetch via the `increment` strobe, capture of the 8-bit `instruction` into an internal IR, then a fixed sequence of one-hot bus-source (`rout`) and bus-destination (`ren`) vectors.
- Supports move, load-immediate, add and xor.
- Sits between a top-level run/halt control and the datapath; its outputs connect one-to-one to the datapath control inputs.

Parameters:
- CTRL_W, 16, width of the one-hot `rout`/`ren` vectors.
- IR_W, 8, instruction width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; high = keep fetching and executing; low = finish the current instruction, then park in IDLE.
- instruction  in  IR_W  instruction from the datapath instruction memory; valid one cycle after an `increment` pulse.
- rout  out  CTRL_W  one-hot bus source select.
- ren  out  CTRL_W  one-hot bus load enable; 0 = no load.
- addxor  out  1  immediate-capture strobe in LD1; ALU op select in AL2 (0 = add, 1 = xor).
- increment  out  1  one-cycle program-counter advance pulse.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the final execute cycle of each instruction.
- instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- Interface: one clock named `clock`; reset named `reset`, synchronous and active-high. All outputs are registered, glitch-free, and each held for exactly one cycle per state.
- Reset values:
  - rout = 16'h8000 (UNUSED, bus reads 0); ren = 0.
  - addxor = 0; increment = 0; busy = 0; done = 0.
  - instr_count = 0; IR = 0; state = IDLE.
- One-hot codes:
  - Rn = 1<<n for n = 0..7.
  - G = 1<<8; A = 1<<9; EXTERN = 1<<10; UNUSED = 1<<15.
- Encoding: IR[7:6] = op, IR[5:3] = x, IR[2:0] = y/imm.
  - op 00 = mov Rx←Ry
  - op 01 = ld Rx←imm
  - op 10 = add Rx←Rx+Ry
  - op 11 = xor Rx←Rx^Ry
- Idle-state outputs: in every state not listed below, rout = UNUSED, ren = 0, addxor = 0.
- States and outputs:
  - IDLE: if run, go to FETCH.
  - FETCH: increment = 1; go to WAIT.
  - WAIT: IR ← instruction at the end of the cycle; go to the execute state for op.
  - MV: rout = Ry, ren = Rx, done = 1.
  - LD1: addxor = 1 (datapath captures imm into EXTERN); rout = UNUSED; ren = 0.
  - LD2: rout = EXTERN, ren = Rx, done = 1.
  - AL1: rout = Rx, ren = A.
  - AL2: rout = Ry, ren = G, addxor = op[0].
  - AL3: rout = G, ren = Rx, done = 1.
- After a done state: go to FETCH if run, else IDLE.
- Latency per instruction (FETCH to done, inclusive): mov 3, ld 4, add/xor 5 cycles.
- Counting: instr_count increments on each done cycle and wraps FFFF→0000 with no flag.
- run deassert mid-instruction: the instruction completes; no further `increment` is issued.
- run reassert while IDLE: FETCH in the next cycle.
- Reset mid-sequence:
  - Next-cycle outputs take reset values.
  - No done pulse and no count update for the aborted instruction.
  - The datapath program counter is NOT rewound.
- x == y:
  - Legal for all ops; mov R0,R0 acts as nop.
  - add/xor with x == y use the same register in AL1 and AL2.
- `instruction` is sampled only in WAIT; changes in any other state are ignored.

Decomposition:
- Shared package `datapath_pkg`:
  - one-hot source/destination constants (R0..R7, G, A, EXTERN, UNUSED);
  - opcode constants OP_MOV/OP_LD/OP_ADD/OP_XOR;
  - state encoding (IDLE, FETCH, WAIT, MV, LD1, LD2, AL1, AL2, AL3);
  - IR field positions.
- Sub-module `sequencer_decode`: combinational IR → {op, x_onehot, y_onehot}.
- `instr_sequencer` holds the FSM, output registers and counter.

Test Plan:
1. Reset, run = 1, instruction = 8'b01000001 → FETCH increment = 1; WAIT; LD1 addxor = 1, rout = 8000, ren = 0; LD2 rout = 0400, ren = 0001, done = 1; instr_count = 1.
2. instruction = 8'b10000001 (add R0,R1) → AL1 rout = 0001, ren = 0200; AL2 rout = 0002, ren = 0100, addxor = 0; AL3 rout = 0100, ren = 0001, done = 1.
3. instruction = 8'b11010011 (xor R2,R3) → AL1 rout = 0004, ren = 0200; AL2 rout = 0008, ren = 0100, addxor = 1; AL3 rout = 0100, ren = 0004.
4. instruction = 8'b00101110 (mov R5←R6) → MV rout = 0040, ren = 0020, done = 1; then FETCH the next cycle while run = 1.
5. Drop run during AL2 → AL3 completes with done = 1, then IDLE; increment stays 0 for 10 cycles; busy = 0.
6. Reset asserted in AL2 → next cycle rout = 8000, ren = 0, done = 0, instr_count = 0; also force instr_count = FFFF, retire one instruction → 0000.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the register/G/A/EXTERN bus datapath: one-hot bus codes,
// opcodes, sequencer state encoding and instruction field positions.
package datapath_pkg;

  localparam logic [15:0] ONEHOT_G      = 16'h0100;
  localparam logic [15:0] ONEHOT_A      = 16'h0200;
  localparam logic [15:0] ONEHOT_EXTERN = 16'h0400;
  localparam logic [15:0] ONEHOT_UNUSED = 16'h8000;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LD  = 2'b01,
    OP_ADD = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    WAIT  = 4'd2,
    MV    = 4'd3,
    LD1   = 4'd4,
    LD2   = 4'd5,
    AL1   = 4'd6,
    AL2   = 4'd7,
    AL3   = 4'd8
  } state_t;

  // Register Rn maps to bus bit n.
  function automatic logic [15:0] reg_onehot(input logic [2:0] n);
    return 16'(16'h0001 << n);
  endfunction

endpackage

// File: rtl/sequencer_decode.sv
// Combinational instruction decode: opcode plus one-hot select codes for the
// x (destination) and y (source) register fields.
module sequencer_decode
  import datapath_pkg::*;
#(
  parameter int IR_W   = 8,
  parameter int CTRL_W = 16
) (
  input  logic [IR_W-1:0]   ir,
  output op_t               op,
  output logic [CTRL_W-1:0] x_onehot,
  output logic [CTRL_W-1:0] y_onehot
);

  assign op       = op_t'(ir[OP_MSB:OP_LSB]);
  assign x_onehot = CTRL_W'(reg_onehot(ir[X_MSB:X_LSB]));
  assign y_onehot = CTRL_W'(reg_onehot(ir[Y_MSB:Y_LSB]));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the bus datapath. Every output is registered and
// computed from the next state, so each output lines up exactly with its state.
module instr_sequencer
  import datapath_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int IR_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [IR_W-1:0]   instruction,
  output logic [CTRL_W-1:0] rout,
  output logic [CTRL_W-1:0] ren,
  output logic              addxor,
  output logic              increment,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count
);

  state_t            state_q, state_next;
  logic [IR_W-1:0]   ir_q, ir_next;
  logic [CTRL_W-1:0] rout_q, ren_q, rout_next, ren_next;
  logic              addxor_q, inc_q, busy_q, done_q;
  logic              addxor_next, inc_next, busy_next, done_next;
  logic [CNT_W-1:0]  count_q;

  op_t               op;
  logic [CTRL_W-1:0] x_onehot, y_onehot;

  // Decode the word being captured during WAIT so the first execute state's
  // registered outputs are ready on the same edge that loads IR.
  assign ir_next = (state_q == WAIT) ? instruction : ir_q;

  sequencer_decode #(
    .IR_W   (IR_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .ir       (ir_next),
    .op       (op),
    .x_onehot (x_onehot),
    .y_onehot (y_onehot)
  );

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      IDLE:  state_next = run ? FETCH : IDLE;
      FETCH: state_next = WAIT;
      WAIT: begin
        unique case (op)
          OP_MOV: state_next = MV;
          OP_LD:  state_next = LD1;
          default: state_next = AL1;
        endcase
      end
      LD1: state_next = LD2;
      AL1: state_next = AL2;
      AL2: state_next = AL3;
      MV, LD2, AL3: state_next = run ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rout_next   = CTRL_W'(ONEHOT_UNUSED);
    ren_next    = '0;
    addxor_next = 1'b0;
    inc_next    = 1'b0;
    done_next   = 1'b0;
    busy_next   = (state_next != IDLE);
    unique case (state_next)
      FETCH: inc_next = 1'b1;
      MV: begin
        rout_next = y_onehot;
        ren_next  = x_onehot;
        done_next = 1'b1;
      end
      LD1: addxor_next = 1'b1;
      LD2: begin
        rout_next = CTRL_W'(ONEHOT_EXTERN);
        ren_next  = x_onehot;
        done_next = 1'b1;
      end
      AL1: begin
        rout_next = x_onehot;
        ren_next  = CTRL_W'(ONEHOT_A);
      end
      AL2: begin
        rout_next   = y_onehot;
        ren_next    = CTRL_W'(ONEHOT_G);
        addxor_next = (op == OP_XOR);
      end
      AL3: begin
        rout_next = CTRL_W'(ONEHOT_G);
        ren_next  = x_onehot;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      rout_q   <= CTRL_W'(ONEHOT_UNUSED);
      ren_q    <= '0;
      addxor_q <= 1'b0;
      inc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_next;
      ir_q     <= ir_next;
      rout_q   <= rout_next;
      ren_q    <= ren_next;
      addxor_q <= addxor_next;
      inc_q    <= inc_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
      // Retire at the end of the done cycle; wraps silently.
      count_q  <= count_q + CNT_W'(done_q);
    end
  end

  assign rout        = rout_q;
  assign ren         = ren_q;
  assign addxor      = addxor_q;
  assign increment   = inc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-cycle expected output vectors are
// queued from an instruction-level model and compared on the falling edge.
module tb_instr_sequencer;

  logic        clock;
  logic        reset;
  logic        run;
  logic [7:0]  instruction;
  logic [15:0] rout, ren;
  logic        addxor, increment, busy, done;
  logic [15:0] instr_count;

  typedef struct {
    logic [15:0] rout;
    logic [15:0] ren;
    logic        addxor;
    logic        inc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] exp_cnt = 16'h0000;

  instr_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .rout        (rout),
    .ren         (ren),
    .addxor      (addxor),
    .increment   (increment),
    .busy        (busy),
    .done        (done),
    .instr_count (instr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic push(input logic [15:0] r, input logic [15:0] e, input logic a,
                      input logic i, input logic b, input logic d);
    exp_t t;
    t.rout = r; t.ren = e; t.addxor = a; t.inc = i; t.busy = b; t.done = d;
    sb.push_back(t);
  endtask

  // Instruction-level reference: FETCH, WAIT, then the execute states for op.
  task automatic model(input logic [7:0] ins);
    logic [1:0]  op;
    logic [15:0] xs, ys;
    op = ins[7:6];
    xs = 16'h0001 << ins[5:3];
    ys = 16'h0001 << ins[2:0];
    push(16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    push(16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    case (op)
      2'b00: push(ys, xs, 1'b0, 1'b0, 1'b1, 1'b1);
      2'b01: begin
        push(16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        push(16'h0400, xs, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      default: begin
        push(xs, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0);
        push(ys, 16'h0100, op[0], 1'b0, 1'b1, 1'b0);
        push(16'h0100, xs, 1'b0, 1'b0, 1'b1, 1'b1);
      end
    endcase
  endtask

  // Runs one instruction from the cycle before FETCH. drop_at / reset_at give the
  // cycle index (0 = FETCH) after which run is dropped or reset is raised.
  task automatic exec(input logic [7:0] ins, input int drop_at, input int reset_at);
    int   n;
    exp_t e;
    model(ins);
    n   = sb.size();
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      vectors++;
      if ({rout, ren, addxor, increment, busy, done, instr_count} !==
          {e.rout, e.ren, e.addxor, e.inc, e.busy, e.done, exp_cnt}) begin
        errors++;
        $display("FAIL exec ins=%02h cyc%0d: got rout=%04h ren=%04h ax=%b inc=%b busy=%b done=%b cnt=%04h, want rout=%04h ren=%04h ax=%b inc=%b busy=%b done=%b cnt=%04h",
                 ins, k, rout, ren, addxor, increment, busy, done, instr_count,
                 e.rout, e.ren, e.addxor, e.inc, e.busy, e.done, exp_cnt);
      end
      instruction = (k == 1) ? ins : 8'($urandom);
      if (e.done) exp_cnt++;
      if (k == drop_at) run = 1'b0;
      if (k == reset_at) begin
        reset = 1'b1;
        sb.delete();
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
      instruction = 8'($urandom);
      vectors++;
      if ({rout, ren, addxor, increment, busy, done, instr_count} !==
          {16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt}) begin
        errors++;
        $display("FAIL %s idle%0d: got rout=%04h ren=%04h ax=%b inc=%b busy=%b done=%b cnt=%04h, want idle outputs cnt=%04h",
                 tag, k, rout, ren, addxor, increment, busy, done, instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; instruction = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({rout, ren, addxor, increment, busy, done, instr_count} !==
        {16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: got rout=%04h ren=%04h ax=%b inc=%b busy=%b done=%b cnt=%04h, want 8000/0000/0/0/0/0/0000",
               rout, ren, addxor, increment, busy, done, instr_count);
    end
    reset = 1'b0;
    exp_cnt = 16'h0000;
    idle_cycles(3, "run_low");
  endtask

  task automatic test_load();   exec(8'b01000001, -1, -1); endtask
  task automatic test_add();    exec(8'b10000001, -1, -1); endtask
  task automatic test_xor();    exec(8'b11010011, -1, -1); endtask
  task automatic test_mov();    exec(8'b00101110, -1, -1); endtask

  task automatic test_back_to_back();
    exec(8'h00, -1, -1);          // mov R0,R0
    exec(8'b10011011, -1, -1);    // add R3,R3
    exec(8'b11111111, -1, -1);    // xor R7,R7
    exec(8'b01111101, -1, -1);    // ld R7,5
    for (int i = 0; i < 6; i++) exec(8'($urandom), -1, -1);
  endtask

  task automatic test_run_drop();
    exec(8'b10000001, -1, -1);
    exec(8'b10010100, 3, -1);     // run drops during AL2
    idle_cycles(10, "run_drop");
  endtask

  task automatic test_reset_mid();
    exec(8'b10001010, -1, 3);     // reset raised during AL2
    run = 1'b0;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({rout, ren, done, increment, busy, instr_count} !==
        {16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_mid: got rout=%04h ren=%04h done=%b inc=%b busy=%b cnt=%04h, want 8000/0000/0/0/0/0000",
               rout, ren, done, increment, busy, instr_count);
    end
    reset = 1'b0;
    exp_cnt = 16'h0000;
    idle_cycles(2, "after_reset");
  endtask

  task automatic test_wrap();
    force dut.count_q = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    release dut.count_q;
    exp_cnt = 16'hFFFF;
    exec(8'b00001010, 2, -1);     // mov R1,R2, then park
    idle_cycles(2, "wrap");
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_xor();
    test_mov();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, want completion");
    $fatal(1, "timeout");
  end

endmodule
